// File: rtl/alu_dot_sequencer.sv
// Dot-product sequencer: fetches A/B operand pairs from a synchronous memory,
// drives the external ALU through MUL then ADD per element, and reports the sum.
module alu_dot_sequencer #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_a,
  input  logic [AW-1:0] base_b,
  input  logic [LW-1:0] len,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_c,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          ovf
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ZER = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_RDA, S_RDB, S_MUL, S_ACC, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] base_a_q, base_a_d;
  logic [AW-1:0] base_b_q, base_b_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] prod_q, prod_d;
  logic [DW-1:0] a_reg_q, a_reg_d;
  logic [DW-1:0] result_q, result_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          mem_rd_q, mem_rd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;

  // The ALU only returns the low DW bits, so the carry is rebuilt here.
  function automatic logic add_carry(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[DW];
  endfunction

  always_comb begin
    state_d  = state_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    len_d    = len_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    a_reg_d  = a_reg_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    alu_op   = OP_ZER;
    alu_a    = '0;
    alu_b    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_a_d = base_a;
          base_b_d = base_b;
          len_d    = len;
          idx_d    = '0;
          ovf_d    = 1'b0;
          result_d = '0;
          state_d  = S_CLR;
        end
      end
      S_CLR: begin
        acc_d   = alu_c;
        state_d = (len_q == '0) ? S_DONE : S_RDA;
      end
      S_RDA: state_d = S_RDB;
      S_RDB: begin
        a_reg_d = mem_rdata;
        state_d = S_MUL;
      end
      S_MUL: begin
        alu_op  = OP_MUL;
        alu_a   = a_reg_q;
        alu_b   = mem_rdata;
        prod_d  = alu_c;
        state_d = S_ACC;
      end
      S_ACC: begin
        alu_op = OP_ADD;
        alu_a  = acc_q;
        alu_b  = prod_q;
        acc_d  = alu_c;
        ovf_d  = ovf_q | add_carry(acc_q, prod_q);
        if (idx_q == len_q - LW'(1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + LW'(1);
          state_d = S_RDA;
        end
      end
      S_DONE: begin
        result_d = acc_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so they line up with it.
    mem_rd_d   = (state_d == S_RDA) || (state_d == S_RDB);
    mem_addr_d = mem_addr_q;
    if (state_d == S_RDA) mem_addr_d = base_a_q + AW'(idx_d);
    if (state_d == S_RDB) mem_addr_d = base_b_q + AW'(idx_q);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_a_q   <= '0;
      base_b_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      prod_q     <= '0;
      a_reg_q    <= '0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      base_a_q   <= base_a_d;
      base_b_q   <= base_b_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      prod_q     <= prod_d;
      a_reg_q    <= a_reg_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ovf      = ovf_q;
  // Final sum is forwarded during DONE so it is valid alongside the pulse.
  assign result   = (state_q == S_DONE) ? acc_q : result_q;

endmodule

// File: tb/tb_alu_dot_sequencer.sv
// Directed bench for alu_dot_sequencer with a behavioural ALU and sync memory.
module tb_alu_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_a = '0;
  logic [7:0]  base_b = '0;
  logic [7:0]  len = '0;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata = '0;
  logic [2:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_c;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovf;

  logic [15:0] mem [0:255];
  logic [7:0]  rd_log [0:15];
  int          nrd;
  int          checks = 0;
  int          errors = 0;

  alu_dot_sequencer #(.DW(16), .AW(8), .LW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_a(base_a), .base_b(base_b),
    .len(len), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .busy(busy), .done(done), .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always_comb begin
    logic [31:0] p;
    p = 32'(alu_a) * 32'(alu_b);
    case (alu_op)
      3'd0:    alu_c = alu_a + alu_b;
      3'd1:    alu_c = alu_a - alu_b;
      3'd2:    alu_c = alu_a;
      3'd4:    alu_c = p[15:0];
      3'd5:    alu_c = p[31:16];
      default: alu_c = '0;
    endcase
  end

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_result"}, 32'(result), 0);
    check({tag, "_ovf"}, 32'(ovf), 0);
    check({tag, "_mem_rd"}, 32'(mem_rd), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_alu_op"}, 32'(alu_op), 3);
  endtask

  // Called #1 after an edge; returns cycle number of done (-1 timeout, -2 reset).
  task automatic run_job(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] ln,
                         input int inj, input int rst_at,
                         output int dcyc, output logic [15:0] res, output logic ov);
    int cyc;
    nrd = 0; dcyc = -1; res = '0; ov = 1'b0;
    base_a = ba; base_b = bb; len = ln; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    check("busy_rise", 32'(busy), 1);
    while (cyc < 200) begin
      if (mem_rd && nrd < 16) begin rd_log[nrd] = mem_addr; nrd++; end
      if (done) begin dcyc = cyc; res = result; ov = ovf; break; end
      if (cyc == rst_at) begin
        rst_n = 1'b0; #1;
        check_reset_outputs("midrst");
        rst_n = 1'b1; dcyc = -2;
        break;
      end
      if (cyc == inj) begin
        start = 1'b1; base_a = 8'h00; base_b = 8'h00; len = 8'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  initial begin
    int          dc;
    logic [15:0] r;
    logic        o;
    logic [7:0]  exp_addr [0:5];

    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3 + 1);
    mem[8'h10] = 16'd1; mem[8'h11] = 16'd2; mem[8'h12] = 16'd3;
    mem[8'h20] = 16'd4; mem[8'h21] = 16'd5; mem[8'h22] = 16'd6;
    mem[8'h30] = 16'hFFFF; mem[8'h31] = 16'd2;
    mem[8'h40] = 16'd1;    mem[8'h41] = 16'd1;
    mem[8'h50] = 16'h0100; mem[8'h60] = 16'h0100;
    mem[8'h70] = 16'd7;    mem[8'h80] = 16'd6;
    exp_addr[0] = 8'h10; exp_addr[1] = 8'h20; exp_addr[2] = 8'h11;
    exp_addr[3] = 8'h21; exp_addr[4] = 8'h12; exp_addr[5] = 8'h22;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst_rel");

    run_job(8'h10, 8'h20, 8'd3, 5, -1, dc, r, o);
    check("basic_done_cyc", dc, 14);
    check("basic_result", 32'(r), 32);
    check("basic_ovf", 32'(o), 0);
    check("basic_nrd", nrd, 6);
    for (int i = 0; i < 6; i++) check($sformatf("basic_addr%0d", i), 32'(rd_log[i]), 32'(exp_addr[i]));
    @(posedge clk); #1;
    check("basic_busy_drop", 32'(busy), 0);
    check("basic_result_held", 32'(result), 32);

    run_job(8'h12, 8'h22, 8'd1, -1, -1, dc, r, o);
    check("restart_done_cyc", dc, 6);
    check("restart_result", 32'(r), 18);
    @(posedge clk); #1;

    run_job(8'h10, 8'h20, 8'd0, -1, -1, dc, r, o);
    check("zero_done_cyc", dc, 2);
    check("zero_result", 32'(r), 0);
    check("zero_nrd", nrd, 0);
    @(posedge clk); #1;
    check("zero_mem_rd_after", 32'(mem_rd), 0);

    run_job(8'h30, 8'h40, 8'd2, -1, -1, dc, r, o);
    check("ovf_done_cyc", dc, 10);
    check("ovf_result", 32'(r), 16'h0001);
    check("ovf_flag", 32'(o), 1);
    @(posedge clk); #1;
    check("ovf_sticky_after", 32'(ovf), 1);

    run_job(8'h50, 8'h60, 8'd1, -1, -1, dc, r, o);
    check("trunc_result", 32'(r), 0);
    check("trunc_ovf", 32'(o), 0);
    @(posedge clk); #1;

    run_job(8'h10, 8'h20, 8'd3, -1, 7, dc, r, o);
    check("midrst_taken", dc, -2);
    run_job(8'h70, 8'h80, 8'd1, -1, -1, dc, r, o);
    check("postrst_done_cyc", dc, 6);
    check("postrst_result", 32'(r), 42);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_dot_sequencer.md
# alu_dot_sequencer

Sequencer that owns the 16-bit ALU (ops ADD=0, SUB=1, PASS=2, ZER=3, MUL=4, MULM=5) and drives it to compute a dot product of two vectors held in a shared synchronous operand memory. It sits between the matrix-multiply top-level control, which issues one `start` per output element, and the ALU/memory datapath. It fetches the operands, issues MUL then ADD per element, accumulates, and reports the result with a done pulse.

## Interface
- `DW`, 16: data width. Must match the ALU bus width.
- `AW`, 8: operand memory address width.
- `LW`, 8: vector length width. Maximum length is 2^LW − 1.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a dot product; sampled only in IDLE.
- `base_a`  in  AW  address of the first A element; latched on accepted start.
- `base_b`  in  AW  address of the first B element; latched on accepted start.
- `len`  in  LW  number of elements; latched on accepted start.
- `mem_rd`  out  1  memory read strobe.
- `mem_addr`  out  AW  memory read address.
- `mem_rdata`  in  DW  read data; valid exactly one cycle after the `mem_rd` cycle.
- `alu_op`  out  3  ALU opcode.
- `alu_a`  out  DW  ALU A_bus.
- `alu_b`  out  DW  ALU B_bus.
- `alu_c`  in  DW  ALU C_bus; combinational result in the same cycle.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when the result is final.
- `result`  out  DW  final accumulator value; held until the next accepted start.
- `ovf`  out  1  sticky accumulate-carry flag for the current job.

## Operation
- The FSM has seven states: IDLE, CLR, RDA, RDB, MUL, ACC, DONE.
- **IDLE**
  - `alu_op`=ZER, `alu_a`=`alu_b`=0, `mem_rd`=0.
  - On `start`=1: latch `base_a`, `base_b`, `len`; clear `idx`, `ovf` and `result`; go to CLR.
- **CLR**
  - `alu_op`=ZER; `acc` <= `alu_c` (0).
  - If `len`==0, go to DONE; otherwise go to RDA.
- **RDA**
  - `mem_rd`=1, `mem_addr`=`base_a`+`idx` (mod 2^AW). Go to RDB.
- **RDB**
  - `mem_rd`=1, `mem_addr`=`base_b`+`idx`; `a_reg` <= `mem_rdata`. Go to MUL.
- **MUL**
  - `alu_op`=MUL, `alu_a`=`a_reg`, `alu_b`=`mem_rdata`; `prod` <= `alu_c`. Go to ACC.
  - `prod` is the low DW bits of the product. Product truncation does not set `ovf`.
- **ACC**
  - `alu_op`=ADD, `alu_a`=`acc`, `alu_b`=`prod`; `acc` <= `alu_c`.
  - `ovf` <= `ovf` | carry-out, where carry-out is the internally computed bit DW of `acc`+`prod`.
  - If `idx`==`len`−1, go to DONE; otherwise `idx` <= `idx`+1 and go to RDA.
- **DONE**
  - `done`=1, `result` <= `acc`. Go to IDLE.
- The `result` register becomes visible the cycle after DONE. The final value is also presented combinationally on `result` during DONE (mux `acc`), so it is valid while `done` is high.
- `start` outside IDLE is ignored; there is no queuing.
- Outputs when no read is active: `mem_addr` holds its last value, and `alu_op`/`alu_a`/`alu_b` hold their IDLE values outside MUL/ACC/CLR.
- `rst_n` low at any time, including mid-job:
  - the FSM goes to IDLE;
  - `acc`, `prod`, `a_reg`, `idx`, `result`, `ovf`, `done`, `busy`, `mem_rd` and `mem_addr` all go to 0;
  - `alu_op` goes to ZER (3);
  - the partial job is discarded.
- All arithmetic is modulo 2^DW.

## Timing
- Cycle 0 is the edge where `start` is sampled in IDLE.
- Cycle 1 is CLR; `busy` rises here.
- Element k occupies cycles 2+4k through 5+4k (RDA, RDB, MUL, ACC).
- DONE is at cycle 2+4·`len`, with `done`=1. For `len`=0, DONE is at cycle 2.
- `busy` drops at cycle 3+4·`len`, and a new `start` is accepted from that cycle.
- Throughput is 4 cycles per element plus 2 cycles of overhead.

## Test plan
- **Reset values:** assert `rst_n`=0, then release → `busy`=0, `done`=0, `result`=0, `ovf`=0, `mem_rd`=0, `alu_op`=3.
- **Basic dot product:** mem A@0x10 = {1,2,3}, B@0x20 = {4,5,6}; `len`=3 → `done` at cycle 14, `result`=32, `ovf`=0. `mem_addr` sequence is 0x10, 0x20, 0x11, 0x21, 0x12, 0x22.
- **Zero length:** `len`=0 → `done` at cycle 2, `result`=0, and `mem_rd` never asserts.
- **Accumulate overflow and truncation:**
  - A={0xFFFF,2}, B={1,1}, `len`=2 → `result`=0x0001, `ovf`=1.
  - A={0x0100}, B={0x0100}, `len`=1 → `result`=0x0000, `ovf`=0.
- **Start while busy:** pulse `start` at cycle 5 of a `len`=3 job → ignored, and the first job completes unchanged. A `start` at cycle 15 is accepted.
- **Reset mid-job:** drop `rst_n` at cycle 7 → all outputs return to reset values immediately. A new `len`=1 job, A={7}, B={6}, then yields `result`=42 at cycle 6.
